// File: rtl/uart_pkg.sv
// Shared definitions for the UART bus controllers: register word offsets,
// STATUS/CTRL/CMD bit positions and the transmit frame state encoding.
package uart_pkg;

  localparam logic [2:0] UART_DATA   = 3'd0;
  localparam logic [2:0] UART_STATUS = 3'd1;
  localparam logic [2:0] UART_DIV    = 3'd2;
  localparam logic [2:0] UART_CTRL   = 3'd3;
  localparam logic [2:0] UART_CMD    = 3'd4;

  localparam int unsigned ST_BUSY    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_LVL_LSB = 8;

  localparam int unsigned CTRL_PAR_EN  = 0;
  localparam int unsigned CTRL_PAR_ODD = 1;
  localparam int unsigned CTRL_STOP2   = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;
  localparam int unsigned CTRL_LVL_LSB = 8;

  localparam int unsigned CMD_FLUSH   = 0;
  localparam int unsigned CMD_CLR_OVF = 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word fall-through synchronous FIFO with flush; rd_data always shows the head entry.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // Flush beats both push and pop; a push into a full FIFO is dropped regardless of pop.
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo_sb_ctrl.sv
// System-bus UART transmitter: register decode, config registers, TX FIFO,
// baud counter and frame serialiser running frames back-to-back.
module uart_tx_fifo_sb_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned DEFAULT_DIV = 5208
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] addr_i,
  input  logic        req_i,
  input  logic [31:0] WD_i,
  input  logic        WE_i,
  output logic [31:0] RD_o,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BIT_W = $clog2(DATA_W);

  logic [2:0]        off;
  logic              wr_data_reg, wr_div, wr_ctrl, wr_cmd, rd_req;
  logic              flush, clr_ovf;
  logic [DIV_W-1:0]  div_q, div_eff;
  logic              par_en_q, par_odd_q, stop2_q, irq_en_q, ovf_q;
  logic [7:0]        irq_lvl_q;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, pop_req;
  logic [LVL_W-1:0]  fifo_level;
  tx_state_e         state_q, state_n;
  logic [DIV_W-1:0]  cnt_q, sh_div_q;
  logic [DATA_W-1:0] shreg_q;
  logic [BIT_W-1:0]  bit_idx_q;
  logic              sh_par_en_q, sh_stop2_q, par_q, stop_2nd_q, bit_done, busy;
  logic [31:0]       rd_val;
  logic              unused_bits;

  assign off         = addr_i[4:2];
  assign rd_req      = req_i && !WE_i;
  assign wr_data_reg = req_i && WE_i && (off == UART_DATA);
  assign wr_div      = req_i && WE_i && (off == UART_DIV);
  assign wr_ctrl     = req_i && WE_i && (off == UART_CTRL);
  assign wr_cmd      = req_i && WE_i && (off == UART_CMD);
  assign flush       = wr_cmd && WD_i[CMD_FLUSH];
  assign clr_ovf     = wr_cmd && WD_i[CMD_CLR_OVF];
  assign div_eff     = (div_q == '0) ? DIV_W'(1) : div_q;
  assign bit_done    = (cnt_q == '0);
  assign busy        = (state_q != IDLE);
  assign irq_o       = irq_en_q && (8'(fifo_level) <= irq_lvl_q);
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], WD_i};

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push    (wr_data_reg),
    .pop     (pop_req),
    .flush   (flush),
    .wr_data (WD_i[DATA_W-1:0]),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q     <= DIV_W'(DEFAULT_DIV);
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      irq_lvl_q <= '0;
      ovf_q     <= 1'b0;
      RD_o      <= '0;
    end else begin
      if (wr_div) div_q <= WD_i[DIV_W-1:0];
      if (wr_ctrl) begin
        par_en_q  <= WD_i[CTRL_PAR_EN];
        par_odd_q <= WD_i[CTRL_PAR_ODD];
        stop2_q   <= WD_i[CTRL_STOP2];
        irq_en_q  <= WD_i[CTRL_IRQ_EN];
        irq_lvl_q <= WD_i[CTRL_LVL_LSB +: 8];
      end
      if (clr_ovf) ovf_q <= 1'b0;
      else if (wr_data_reg && fifo_full) ovf_q <= 1'b1;
      if (rd_req) RD_o <= rd_val;
    end
  end

  always_comb begin
    rd_val = '0;
    case (off)
      UART_STATUS: begin
        rd_val[ST_BUSY]            = busy;
        rd_val[ST_EMPTY]           = fifo_empty;
        rd_val[ST_FULL]            = fifo_full;
        rd_val[ST_OVF]             = ovf_q;
        rd_val[ST_LVL_LSB +: 8]    = 8'(fifo_level);
      end
      UART_DIV:  rd_val[DIV_W-1:0] = div_q;
      UART_CTRL: begin
        rd_val[CTRL_PAR_EN]        = par_en_q;
        rd_val[CTRL_PAR_ODD]       = par_odd_q;
        rd_val[CTRL_STOP2]         = stop2_q;
        rd_val[CTRL_IRQ_EN]        = irq_en_q;
        rd_val[CTRL_LVL_LSB +: 8]  = irq_lvl_q;
      end
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    pop_req = 1'b0;
    tx_o    = 1'b1;
    case (state_q)
      IDLE: if (!fifo_empty) begin
        pop_req = 1'b1;
        state_n = START;
      end
      START: begin
        tx_o = 1'b0;
        if (bit_done) state_n = DATA;
      end
      DATA: begin
        tx_o = shreg_q[0];
        if (bit_done && bit_idx_q == BIT_W'(DATA_W - 1))
          state_n = sh_par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_o = par_q;
        if (bit_done) state_n = STOP;
      end
      STOP: if (bit_done && (!sh_stop2_q || stop_2nd_q)) begin
        // Chain straight into the next frame so there is no idle gap.
        if (!fifo_empty) begin
          pop_req = 1'b1;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      pop_req = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      sh_div_q    <= DIV_W'(1);
      shreg_q     <= '0;
      bit_idx_q   <= '0;
      sh_par_en_q <= 1'b0;
      sh_stop2_q  <= 1'b0;
      par_q       <= 1'b0;
      stop_2nd_q  <= 1'b0;
    end else if (pop_req) begin
      // Frame config is captured here so bus writes only affect later frames.
      shreg_q     <= fifo_rd_data;
      sh_div_q    <= div_eff;
      cnt_q       <= div_eff - DIV_W'(1);
      sh_par_en_q <= par_en_q;
      sh_stop2_q  <= stop2_q;
      par_q       <= (^fifo_rd_data) ^ par_odd_q;
      bit_idx_q   <= '0;
      stop_2nd_q  <= 1'b0;
    end else if (state_q != IDLE) begin
      if (bit_done) begin
        cnt_q <= sh_div_q - DIV_W'(1);
        if (state_q == DATA) begin
          shreg_q   <= {1'b0, shreg_q[DATA_W-1:1]};
          bit_idx_q <= bit_idx_q + BIT_W'(1);
        end
        if (state_q == STOP) stop_2nd_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q - DIV_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_sb_ctrl.sv
// Directed bench for uart_tx_fifo_sb_ctrl: bus register access, frame timing,
// parity/stop options, FIFO overflow, flush and reset behaviour.
module tb_uart_tx_fifo_sb_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] addr_i = '0;
  logic        req_i = 1'b0;
  logic [31:0] WD_i = '0;
  logic        WE_i = 1'b0;
  logic [31:0] RD_o;
  logic        tx_o;
  logic        irq_o;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [63:0] s_bits;
  int          s_div;
  logic [31:0] rdat;

  uart_tx_fifo_sb_ctrl #(
    .DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16), .DEFAULT_DIV(5208)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .addr_i (addr_i),
    .req_i  (req_i),
    .WD_i   (WD_i),
    .WE_i   (WE_i),
    .RD_o   (RD_o),
    .tx_o   (tx_o),
    .irq_o  (irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not reach the end, observed running expected finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; WD_i = d; WE_i = 1'b1; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0; WE_i = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr_i = a; WE_i = 1'b0; req_i = 1'b1;
    @(posedge clk_i); #1;
    req_i = 1'b0;
    d = RD_o;
  endtask

  // Checks tx_o once per clock for stream cycles [c_from, c_to); bit k lasts s_div clocks.
  task automatic chk_seg(input string tag, input int c_from, input int c_to);
    for (int c = c_from; c < c_to; c++) begin
      chk($sformatf("%s[%0d]", tag, c), 32'(tx_o), 32'(s_bits[c / s_div]));
      step(1);
    end
  endtask

  function automatic logic [63:0] fr(input logic [7:0] b);
    return {54'b0, 1'b1, b, 1'b0};
  endfunction

  initial begin
    // Reset values
    #2;
    chk("rst_tx", 32'(tx_o), 32'd1);
    chk("rst_rd", RD_o, 32'h0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step(1);
    bus_read(32'h08, rdat); chk("rst_div", rdat, 32'h0000_1458);
    bus_read(32'h0C, rdat); chk("rst_ctrl", rdat, 32'h0);
    bus_read(32'h04, rdat); chk("rst_status", rdat, 32'h0000_0002);
    bus_read(32'h00, rdat); chk("data_read", rdat, 32'h0);
    bus_write(32'h18, 32'hFFFF_FFFF);
    bus_read(32'h08, rdat); chk("bad_wr_div", rdat, 32'h0000_1458);
    bus_read(32'h14, rdat); chk("bad_rd", rdat, 32'h0);

    // 1: DIV=4, 0xA5, STATUS read held through the frame
    bus_write(32'h08, 32'd4);
    bus_write(32'h00, 32'hA5);
    step(1);
    addr_i = 32'h04; WE_i = 1'b0; req_i = 1'b1;
    s_bits = fr(8'hA5); s_div = 4;
    chk_seg("t1_tx", 0, 40);
    chk("t1_busy_end", RD_o, 32'h0000_0003);
    step(1);
    chk("t1_idle", RD_o, 32'h0000_0002);
    req_i = 1'b0;

    // DIV=0 behaves as one clock per bit
    bus_write(32'h08, 32'd0);
    bus_write(32'h00, 32'h5A);
    step(1);
    s_bits = fr(8'h5A); s_div = 1;
    chk_seg("div0_tx", 0, 10);
    chk("div0_idle_tx", 32'(tx_o), 32'd1);
    bus_read(32'h04, rdat); chk("div0_status", rdat, 32'h0000_0002);

    // 2: three back-to-back frames at DIV=2
    bus_write(32'h08, 32'd2);
    bus_write(32'h00, 32'h3C);
    bus_write(32'h00, 32'h81);
    bus_write(32'h00, 32'h5A);
    addr_i = 32'h04; WE_i = 1'b0; req_i = 1'b1;
    s_bits = (fr(8'h5A) << 20) | (fr(8'h81) << 10) | fr(8'h3C); s_div = 2;
    chk_seg("t2_tx", 1, 11);
    chk("t2_lvl2", RD_o, 32'h0000_0201);
    chk_seg("t2_tx", 11, 31);
    chk("t2_lvl1", RD_o, 32'h0000_0101);
    chk_seg("t2_tx", 31, 51);
    chk("t2_lvl0", RD_o, 32'h0000_0003);
    chk_seg("t2_tx", 51, 60);
    chk("t2_busy_end", RD_o, 32'h0000_0003);
    step(1);
    chk("t2_idle", RD_o, 32'h0000_0002);
    req_i = 1'b0;

    // 3: parity even/odd, then two stop bits between chained frames
    bus_write(32'h0C, 32'h1);
    bus_write(32'h00, 32'h07);
    step(1);
    s_bits = {53'b0, 1'b1, 1'b1, 8'h07, 1'b0};
    chk_seg("t3_even", 0, 22);
    chk("t3_even_idle", 32'(tx_o), 32'd1);
    bus_write(32'h0C, 32'h3);
    bus_write(32'h00, 32'h07);
    step(1);
    s_bits = {53'b0, 1'b1, 1'b0, 8'h07, 1'b0};
    chk_seg("t3_odd", 0, 22);
    bus_write(32'h0C, 32'h4);
    bus_write(32'h00, 32'h07);
    bus_write(32'h00, 32'h07);
    s_bits = {42'b0, 2'b11, 8'h07, 1'b0, 2'b11, 8'h07, 1'b0};
    chk_seg("t3_stop2", 0, 44);
    chk("t3_stop2_idle", 32'(tx_o), 32'd1);
    bus_read(32'h04, rdat); chk("t3_status", rdat, 32'h0000_0002);

    // 4: fill FIFO behind a running frame, overflow, irq, extra byte dropped
    bus_write(32'h0C, 32'h0F08);
    bus_write(32'h08, 32'd8);
    chk("t4_irq_empty", 32'(irq_o), 32'd1);
    bus_write(32'h00, 32'hC3);
    for (int k = 0; k < 17; k++) bus_write(32'h00, 32'(8'h40 + 8'(7 * k)));
    bus_read(32'h04, rdat); chk("t4_full_ovf", rdat, 32'h0000_100D);
    chk("t4_irq_full", 32'(irq_o), 32'd0);
    bus_write(32'h10, 32'h2);
    bus_read(32'h04, rdat); chk("t4_ovf_clr", rdat, 32'h0000_1005);
    s_bits = fr(8'hC3); s_div = 8;
    chk_seg("t4_f0", 19, 80);
    for (int k = 0; k < 16; k++) begin
      s_bits = fr(8'h40 + 8'(7 * k));
      chk_seg($sformatf("t4_f%0d", k + 1), 0, 80);
    end
    chk("t4_no_extra_tx", 32'(tx_o), 32'd1);
    step(2);
    chk("t4_no_extra_tx2", 32'(tx_o), 32'd1);
    bus_read(32'h04, rdat); chk("t4_status_end", rdat, 32'h0000_0002);
    chk("t4_irq_end", 32'(irq_o), 32'd1);

    // 5: flush mid-frame, then push immediately followed by flush
    bus_write(32'h0C, 32'h0);
    bus_write(32'h08, 32'd4);
    bus_write(32'h00, 32'h00);
    bus_write(32'h00, 32'h55);
    step(9);
    chk("t5_mid_tx", 32'(tx_o), 32'd0);
    bus_write(32'h10, 32'h1);
    chk("t5_abort_tx", 32'(tx_o), 32'd1);
    bus_read(32'h04, rdat); chk("t5_status", rdat, 32'h0000_0002);
    step(5);
    chk("t5_stay_idle", 32'(tx_o), 32'd1);
    bus_write(32'h00, 32'h11);
    bus_write(32'h10, 32'h1);
    chk("t5_pf_tx", 32'(tx_o), 32'd1);
    bus_read(32'h04, rdat); chk("t5_pf_status", rdat, 32'h0000_0002);
    step(3);
    chk("t5_pf_idle", 32'(tx_o), 32'd1);

    // 6: DIV change mid-frame applies to the following frame only
    bus_write(32'h08, 32'd4);
    bus_write(32'h00, 32'h96);
    bus_write(32'h00, 32'h69);
    bus_write(32'h08, 32'd8);
    s_bits = fr(8'h96); s_div = 4;
    chk_seg("t6_f0", 1, 40);
    s_bits = fr(8'h69); s_div = 8;
    chk_seg("t6_f1", 0, 80);
    chk("t6_idle", 32'(tx_o), 32'd1);

    // Asynchronous reset in the middle of a frame
    bus_write(32'h0C, 32'h0F0F);
    bus_write(32'h00, 32'h00);
    step(13);
    chk("t6_pre_rst_tx", 32'(tx_o), 32'd0);
    bus_read(32'h08, rdat); chk("t6_pre_rst_div", rdat, 32'd8);
    #3 rst_ni = 1'b0;
    #1;
    chk("t6_rst_tx", 32'(tx_o), 32'd1);
    chk("t6_rst_rd", RD_o, 32'h0);
    chk("t6_rst_irq", 32'(irq_o), 32'd0);
    rst_ni = 1'b1;
    step(1);
    chk("t6_post_tx", 32'(tx_o), 32'd1);
    bus_read(32'h08, rdat); chk("t6_post_div", rdat, 32'h0000_1458);
    bus_read(32'h0C, rdat); chk("t6_post_ctrl", rdat, 32'h0);
    bus_read(32'h04, rdat); chk("t6_post_status", rdat, 32'h0000_0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
